period_meas: RTL and testbench
==============================

Name: period_meas

Overview:
- Inverse of the free-running clock divider: measures the period and high time of a slow external or divided signal, in `clk` cycles.
- Used by the calculation/display path to read back the rate of divided clocks and external pulse trains.
- Single-shot measurement with a start/valid handshake and overflow timeout.

Parameters:
- WIDTH, 32, width of the cycle counter and of the period/high_time results.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- sig_in  input  1  asynchronous signal to measure.
- start  input  1  single-cycle request to begin a measurement.
- busy  output  1  high from the cycle after start is accepted until done or timeout.
- valid  output  1  one-cycle pulse; period/high_time updated the same cycle.
- period  output  WIDTH  clk cycles between consecutive sig_in rising edges.
- high_time  output  WIDTH  clk cycles sig_in was high after the first rising edge.
- timeout  output  1  one-cycle pulse; measurement abandoned on counter saturation.

Behaviour:
- Reset: clk only, synchronous, active-high. All outputs 0, FSM to IDLE, counters 0, synchronizer and edge register 0.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give s.
  - Rising edge rise = s & ~s_d.
  - Falling edge fall = ~s & s_d.
  - All edges are seen SYNC_STAGES+1 cycles after the pin; the delay is constant, so it cancels in period.
- FSM states: IDLE, WAIT_EDGE, MEASURE.
  - IDLE: busy=0. When start=1, go to WAIT_EDGE, set cnt=0 and hi_seen_fall=0. busy=1 from the next cycle.
  - WAIT_EDGE: cnt increments each cycle.
    - On rise: cnt<=1, hi_cnt<=1, hi_seen_fall<=0, go to MEASURE.
  - MEASURE: cnt increments each cycle.
    - hi_cnt increments while s=1 and hi_seen_fall=0. fall sets hi_seen_fall.
    - On rise: period<=cnt, high_time<=hi_cnt, valid=1 for that cycle, go to IDLE, busy=0 next cycle.
    - Result for a P-cycle period with H cycles high is period=P, high_time=H.
- Timeout: in WAIT_EDGE or MEASURE, if cnt equals all-ones and no rise occurs that cycle:
  - timeout=1 for that cycle, go to IDLE.
  - period and high_time are unchanged and valid stays 0.
  - Rise and saturation in the same cycle: the rise wins and the result is valid.
- Handshake rules:
  - start is ignored while busy=1, including in the valid or timeout cycle.
  - start in the cycle after valid begins a new measurement.
- Held results: period and high_time hold their last valid values until the next valid or reset.
- Constant signal: sig_in constant high or low ends in timeout. high_time never exceeds period.
- Reset mid-measurement aborts to IDLE with no valid or timeout pulse.

Optional Feature:
- Macro: PERIOD_MEAS_AVG_EN.
- When defined:
  - MEASURE spans 4 consecutive periods, with no counter restart between them.
  - A 2-bit period index counts the rising edges.
  - The accumulator is WIDTH+2 bits.
  - On the 4th rise: period <= accumulated cycles >> 2 (truncated), i.e. the mean of the 4 periods.
  - high_time is from the first period only.
  - Timeout applies to the full WIDTH+2-bit accumulator reaching all-ones.
- When undefined: single-period behaviour as above, and no accumulator or index logic is built.

Test Plan:
- Square wave of 10 clk periods, high 3 cycles (WIDTH=32), pulse start → busy rises; valid after second detected rise; period=10, high_time=3; busy=0 next cycle.
- Duty sweep, period 100, high 1 then high 99 → high_time=1 then 99, period=100 both times.
- WIDTH=8, sig_in held 0, start → timeout pulses exactly 255 cycles after entering WAIT_EDGE; valid=0; previous period retained.
- start asserted every cycle during a measurement of period 20 → exactly one valid, period=20; start in the cycle after valid launches a second measurement.
- rst pulsed mid-MEASURE → next cycle busy=0, period=0, no valid/timeout; a later measurement of period 7 returns 7.
- PERIOD_MEAS_AVG_EN defined, periods 10, 11, 12, 13 → period=11 (46>>2), high_time equals first period's high count.

Source files
------------

// File: rtl/period_meas.sv
// rtl/period_meas.sv - single-shot period / high-time measurement of a slow signal in clk cycles
//
// Optional build macro: PERIOD_MEAS_AVG_EN (average over 4 consecutive periods).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sig_in     asynchronous signal to measure
//   start      single-cycle request to begin a measurement
//   busy       high from the cycle after start is accepted until done or timeout
//   valid      one-cycle pulse, period/high_time updated in the same cycle
//   period     clk cycles between consecutive sig_in rising edges
//   high_time  clk cycles sig_in was high after the first rising edge
//   timeout    one-cycle pulse, measurement abandoned on counter saturation
module period_meas #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             timeout
);

`ifdef PERIOD_MEAS_AVG_EN
    localparam int CW = WIDTH + 2;
`else
    localparam int CW = WIDTH;
`endif

    localparam logic [CW-1:0]    CNT_MAX = '1;
    localparam logic [CW-1:0]    CNT_ONE = 1;
    localparam logic [WIDTH-1:0] HI_MAX  = '1;
    localparam logic [WIDTH-1:0] HI_ONE  = 1;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       hi_cnt;
    logic                   hi_seen_fall;
    logic                   saturated;
    logic                   last_rise;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // A rise in the saturating cycle takes priority, so saturation only counts without one.
    assign saturated = (state != IDLE) && (cnt == CNT_MAX) && !rise;
    // Timeout is flagged in the very cycle the counter sits at all-ones; the FSM leaves
    // on that edge. Gated by rst so an aborted measurement never reports a timeout.
    assign timeout   = saturated && !rst;

`ifdef PERIOD_MEAS_AVG_EN
    logic [1:0] idx;
    assign last_rise = (idx == 2'd3);
`else
    assign last_rise = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            valid        <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            cnt          <= '0;
            hi_cnt       <= '0;
            hi_seen_fall <= 1'b0;
`ifdef PERIOD_MEAS_AVG_EN
            idx          <= 2'd0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high in the valid cycle, which blocks a start there.
                    busy <= 1'b0;
                    if (start && !busy) begin
                        state        <= WAIT_EDGE;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        hi_seen_fall <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt          <= CNT_ONE;
                        hi_cnt       <= HI_ONE;
                        hi_seen_fall <= 1'b0;
`ifdef PERIOD_MEAS_AVG_EN
                        idx          <= 2'd0;
`endif
                        state        <= MEASURE;
                    end else if (saturated) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                MEASURE: begin
                    cnt <= cnt + CNT_ONE;
                    // High time is only taken from the first high phase after the opening rise.
                    if (s && !hi_seen_fall && (hi_cnt != HI_MAX))
                        hi_cnt <= hi_cnt + HI_ONE;
                    if (fall)
                        hi_seen_fall <= 1'b1;
                    if (rise) begin
                        if (last_rise) begin
`ifdef PERIOD_MEAS_AVG_EN
                            period <= cnt[CW-1:2];
`else
                            period <= cnt;
`endif
                            high_time <= hi_cnt;
                            valid     <= 1'b1;
                            state     <= IDLE;
                        end
`ifdef PERIOD_MEAS_AVG_EN
                        else begin
                            idx <= idx + 2'd1;
                        end
`endif
                    end else if (saturated) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meas.sv
// tb/tb_period_meas.sv - randomized self-checking bench for period_meas against a waveform-level model
module tb_period_meas;

`ifdef PERIOD_MEAS_AVG_EN
    localparam int NPER = 4;
    localparam int TO8  = 1023;
`else
    localparam int NPER = 1;
    localparam int TO8  = 255;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sig, start, sig8, start8;
    logic        busy, valid, timeout;
    logic [31:0] period, high_time;
    logic        busy8, valid8, timeout8;
    logic [7:0]  period8, high8;

    period_meas #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sig_in(sig), .start(start),
        .busy(busy), .valid(valid), .period(period), .high_time(high_time), .timeout(timeout)
    );

    period_meas #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .sig_in(sig8), .start(start8),
        .busy(busy8), .valid(valid8), .period(period8), .high_time(high8), .timeout(timeout8)
    );

    int checks = 0;
    int passed = 0;
    int wper[4];
    int whi[4];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: mean of the driven periods (truncated), high time of the first one.
    function automatic longint exp_period();
        longint sum = 0;
        for (int i = 0; i < NPER; i++) sum += wper[i];
        return sum / NPER;
    endfunction

    task automatic set_sig(input bit on8, input logic v);
        if (on8) sig8 = v;
        else     sig  = v;
    endtask

    task automatic drive_wave(input bit on8);
        for (int i = 0; i < NPER; i++) begin
            set_sig(on8, 1'b1);
            repeat (whi[i]) @(negedge clk);
            set_sig(on8, 1'b0);
            repeat (wper[i] - whi[i]) @(negedge clk);
        end
        set_sig(on8, 1'b1);
        repeat (2) @(negedge clk);
        set_sig(on8, 1'b0);
    endtask

    task automatic wait_valid(input bit on8, output bit got, output longint per,
                              output longint hi, output int touts);
        got = 0; per = 0; hi = 0; touts = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (on8 ? timeout8 : timeout) touts++;
            if (on8 ? valid8 : valid) begin
                got = 1;
                per = on8 ? longint'(period8) : longint'(period);
                hi  = on8 ? longint'(high8) : longint'(high_time);
            end
        end
    endtask

    task automatic measure(input string tag, input bit on8);
        bit     got;
        longint per, hi;
        int     touts;
        @(negedge clk);
        if (on8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start = 1'b0;
        check({tag, "_busy_rise"}, on8 ? busy8 : busy, 1);
        fork
            drive_wave(on8);
            wait_valid(on8, got, per, hi, touts);
        join
        check({tag, "_valid_seen"}, got, 1);
        check({tag, "_no_timeout"}, touts, 0);
        check({tag, "_period"}, per, exp_period());
        check({tag, "_high_time"}, hi, whi[0]);
        @(negedge clk);
        check({tag, "_busy_fall"}, on8 ? busy8 : busy, 0);
        check({tag, "_valid_pulse"}, on8 ? valid8 : valid, 0);
    endtask

    initial begin
        bit     got, seen;
        longint per, hi;
        int     touts, n, vcount;

        rst = 1'b1; sig = 1'b0; start = 1'b0; sig8 = 1'b0; start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_period8", period8, 0);

        // Square wave 10/3, then the averaging spread 10,11,12,13 with first high 3.
        for (int i = 0; i < 4; i++) begin wper[i] = 10; whi[i] = 3; end
        measure("sq10", 1'b0);
        for (int i = 0; i < 4; i++) begin wper[i] = 10 + i; whi[i] = 3 + i; end
        measure("spread", 1'b0);

        // Duty sweep at period 100.
        for (int i = 0; i < 4; i++) begin wper[i] = 100; whi[i] = 1; end
        measure("duty1", 1'b0);
        for (int i = 0; i < 4; i++) begin wper[i] = 100; whi[i] = 99; end
        measure("duty99", 1'b0);

        // Randomized waveforms.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                wper[i] = int'($urandom_range(60, 2));
                whi[i]  = int'($urandom_range(wper[i] - 1, 1));
            end
            measure($sformatf("rand%0d", r), 1'b0);
        end

        // Narrow instance: establish a result, then let a constant-low input time out.
        for (int i = 0; i < 4; i++) begin wper[i] = 5; whi[i] = 2; end
        measure("w8", 1'b1);
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0; seen = 0; vcount = 0;
        while (n < TO8 + 50 && !seen) begin
            if (timeout8) seen = 1;
            else begin
                if (valid8) vcount++;
                @(negedge clk);
                n++;
            end
        end
        check("to_seen", seen, 1);
        check("to_cycles", n, TO8);
        check("to_no_valid", vcount + int'(valid8), 0);
        check("to_period_held", period8, 5);
        @(negedge clk);
        check("to_busy_fall", busy8, 0);
        check("to_pulse_once", timeout8, 0);

        // start held high through a period-20 measurement.
        for (int i = 0; i < 4; i++) begin wper[i] = 20; whi[i] = 5; end
        @(negedge clk);
        start = 1'b1;
        fork
            drive_wave(1'b0);
            wait_valid(1'b0, got, per, hi, touts);
        join
        check("hold_valid_seen", got, 1);
        check("hold_period", per, exp_period());
        @(negedge clk);
        check("hold_single_valid", valid, 0);
        check("hold_busy_gap", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("hold_relaunch", busy, 1);

        // Move the relaunched measurement into MEASURE, then abort it with reset.
        sig = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_period", period, 0);
        check("abort_valid", valid, 0);
        check("abort_timeout", timeout, 0);
        sig = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin wper[i] = 7; whi[i] = 3; end
        measure("after_rst", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
